// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared state encoding, register map and timing-field layout for lcd_bus_ctrl.
package lcd_bus_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

   localparam logic [1:0] ADDR_CMD    = 2'd0;
   localparam logic [1:0] ADDR_DATA   = 2'd1;
   localparam logic [1:0] ADDR_TIMING = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int FIELD_W    = 8;
   localparam int SETUP_LSB  = 0;
   localparam int STROBE_LSB = 8;
   localparam int HOLD_LSB   = 16;
   localparam int TIM_W      = 24;

   function automatic logic [TIM_W-1:0] tim_pack(input int s, input int w, input int h);
      return {FIELD_W'(h), FIELD_W'(w), FIELD_W'(s)};
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: 8-bit loadable down-counter; done while the count is zero.
module lcd_phase_timer
   import lcd_bus_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load_i,
   input  logic [FIELD_W-1:0] value_i,
   output logic               done_o
);

   logic [FIELD_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         cnt_q <= '0;
      else if (load_i)
         cnt_q <= value_i;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;

   assign done_o = cnt_q == '0;

endmodule

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: Avalon-MM slave sequencing 8080-style LCD command/data cycles.
// Read cycles are built only when LCD_BUS_CTRL_READ_EN is defined.
module lcd_bus_ctrl
   import lcd_bus_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int DEF_SETUP  = 1,
   parameter int DEF_STROBE = 2,
   parameter int DEF_HOLD   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic              read_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              waitrequest,
   output logic              lcd_cs_n,
   output logic              lcd_rs,
   output logic              lcd_wr_n,
   output logic              lcd_rd_n,
   output logic [DATA_W-1:0] lcd_data_out,
   input  logic [DATA_W-1:0] lcd_data_in,
   output logic              lcd_data_oe
);

   state_e              state_q;
   logic [TIM_W-1:0]    tim_q;
   logic [15:0]         shd_q;
   logic                is_rd_q, cs_n_q, wr_n_q, rd_n_q, rs_q, oe_q;
   logic [DATA_W-1:0]   dout_q;
   logic                idle, sel_io, wr_req, rd_req, rd_ack, launch_wr, launch_rd;
   logic                load, done;
   logic [FIELD_W-1:0]  tim_val;
   logic [31:0]         rd_data;
   logic                unused_wd;

   assign idle      = state_q == IDLE;
   assign sel_io    = address == ADDR_CMD || address == ADDR_DATA;
   assign wr_req    = chipselect & ~write_n;
   assign rd_req    = chipselect & ~read_n & write_n;
   assign launch_wr = idle & wr_req & sel_io;
   assign unused_wd = ^writedata[31:24];

`ifdef LCD_BUS_CTRL_READ_EN
   logic              rd_done_q;
   logic [DATA_W-1:0] cap_q;

   assign rd_ack    = idle & rd_done_q;
   assign launch_rd = idle & rd_req & sel_io & ~rd_done_q;
   assign rd_data   = rd_ack ? 32'(cap_q) : '0;
   assign lcd_rd_n  = rd_n_q;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cap_q     <= '0;
         rd_done_q <= 1'b0;
      end else begin
         if (state_q == STROBE && done && is_rd_q)
            cap_q <= lcd_data_in;
         if (state_q == HOLD && done && is_rd_q)
            rd_done_q <= 1'b1;
         else if (rd_ack && rd_req && sel_io)
            rd_done_q <= 1'b0;
      end
`else
   logic unused_rd;

   assign rd_ack    = 1'b1;
   assign launch_rd = 1'b0;
   assign rd_data   = '0;
   assign lcd_rd_n  = 1'b1;
   assign unused_rd = ^{lcd_data_in, rd_n_q};
`endif

   // Reads stall until their own cycle has completed; writes stall only while busy.
   assign waitrequest = sel_io & (wr_req ? ~idle : rd_req & ~rd_ack);
   assign readdata    = !rd_req ? '0 :
                        address == ADDR_TIMING ? {8'h00, tim_q} :
                        address == ADDR_STATUS ? {31'd0, ~idle} : rd_data;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         tim_q <= tim_pack(DEF_SETUP, DEF_STROBE, DEF_HOLD);
      else if (wr_req && address == ADDR_TIMING)
         tim_q <= writedata[TIM_W-1:0];

   // One timer serves all phases: it is reloaded with the next phase length as each phase ends.
   assign load    = idle | (done & state_q != HOLD);
   assign tim_val = idle ? tim_q[SETUP_LSB +: FIELD_W] :
                    state_q == SETUP ? shd_q[7:0] : shd_q[15:8];

   lcd_phase_timer u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (load),
      .value_i (tim_val),
      .done_o  (done)
   );

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         shd_q   <= '0;
         is_rd_q <= 1'b0;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         rs_q    <= 1'b0;
         dout_q  <= '0;
         oe_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE:
               if (launch_wr || launch_rd) begin
                  state_q <= SETUP;
                  shd_q   <= {tim_q[HOLD_LSB +: FIELD_W], tim_q[STROBE_LSB +: FIELD_W]};
                  is_rd_q <= launch_rd;
                  cs_n_q  <= 1'b0;
                  rs_q    <= address[0];
                  oe_q    <= launch_wr;
                  if (launch_wr)
                     dout_q <= writedata[DATA_W-1:0];
               end
            SETUP:
               if (done) begin
                  state_q <= STROBE;
                  wr_n_q  <= is_rd_q;
                  rd_n_q  <= ~is_rd_q;
               end
            STROBE:
               if (done) begin
                  state_q <= HOLD;
                  wr_n_q  <= 1'b1;
                  rd_n_q  <= 1'b1;
               end
            HOLD:
               if (done) begin
                  state_q <= IDLE;
                  cs_n_q  <= 1'b1;
                  oe_q    <= 1'b0;
               end
         endcase
      end

   assign lcd_cs_n     = cs_n_q;
   assign lcd_wr_n     = wr_n_q;
   assign lcd_rs       = rs_q;
   assign lcd_data_out = dout_q;
   assign lcd_data_oe  = oe_q;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl: scoreboard bench for lcd_bus_ctrl; expected LCD cycles and read
// responses are queued by the stimulus and popped by independent monitors.
module tb_lcd_bus_ctrl;

   localparam int DW = 16;

   logic          clk = 1'b0, reset_n = 1'b0;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0, write_n = 1'b1, read_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic          waitrequest;
   logic          lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_oe;
   logic [DW-1:0] lcd_data_out;
   logic [DW-1:0] lcd_data_in = '0;

   int total = 0, bad = 0;

   always #5 clk = ~clk;

   lcd_bus_ctrl #(.DATA_W(DW), .DEF_SETUP(1), .DEF_STROBE(2), .DEF_HOLD(1)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .address      (address),
      .chipselect   (chipselect),
      .write_n      (write_n),
      .read_n       (read_n),
      .writedata    (writedata),
      .readdata     (readdata),
      .waitrequest  (waitrequest),
      .lcd_cs_n     (lcd_cs_n),
      .lcd_rs       (lcd_rs),
      .lcd_wr_n     (lcd_wr_n),
      .lcd_rd_n     (lcd_rd_n),
      .lcd_data_out (lcd_data_out),
      .lcd_data_in  (lcd_data_in),
      .lcd_data_oe  (lcd_data_oe)
   );

   typedef struct {
      logic        rs;
      logic        wr;
      logic [15:0] data;
      int          len, wlen, rlen, soff, gap;
   } lcd_exp_t;

   typedef struct {
      logic [31:0] data;
      int          stall;
   } rd_exp_t;

   lcd_exp_t lcd_q[$];
   rd_exp_t  rd_q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_lcd(input logic rs, input logic wr, input logic [15:0] d,
                           input int s, input int w, input int h, input int gap);
      lcd_exp_t e;
      e.rs   = rs;
      e.wr   = wr;
      e.data = d;
      e.len  = s + w + h + 3;
      e.wlen = wr ? w + 1 : 0;
      e.rlen = wr ? 0 : w + 1;
      e.soff = s + 1;
      e.gap  = gap;
      lcd_q.push_back(e);
   endtask

   // LCD bus monitor: measures each cs_n-low window and compares it to the queue head.
   lcd_exp_t m_e;
   int   m_in = 0, m_len = 0, m_wlen = 0, m_rlen = 0, m_soff = -1, m_oe = 0;
   int   m_gap = 1000, m_cgap = 0;
   logic m_rs = 1'b0;
   logic [15:0] m_data = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         m_in  = 0;
         m_gap = 1000;
      end else if (!lcd_cs_n) begin
         if (m_in == 0) begin
            m_in = 1; m_len = 0; m_wlen = 0; m_rlen = 0; m_soff = -1; m_oe = 0;
            m_rs = lcd_rs; m_cgap = m_gap;
         end
         if ((!lcd_wr_n || !lcd_rd_n) && m_soff < 0) begin
            m_soff = m_len;
            m_data = lcd_data_out;
         end
         m_wlen += int'(!lcd_wr_n);
         m_rlen += int'(!lcd_rd_n);
         m_oe   += int'(lcd_data_oe);
         m_len++;
      end else if (m_in != 0) begin
         m_in  = 0;
         m_gap = 1;
         if (lcd_q.size() == 0)
            chk("lcd_unexpected_cycle", 1, 0);
         else begin
            m_e = lcd_q.pop_front();
            chk("lcd_rs", m_rs, m_e.rs);
            chk("lcd_cs_len", m_len, m_e.len);
            chk("lcd_wr_len", m_wlen, m_e.wlen);
            chk("lcd_rd_len", m_rlen, m_e.rlen);
            chk("lcd_strobe_off", m_soff, m_e.soff);
            chk("lcd_oe_cycles", m_oe, m_e.wr ? m_e.len : 0);
            if (m_e.wr) chk("lcd_data", m_data, m_e.data);
            if (m_e.gap >= 0) chk("lcd_gap", m_cgap, m_e.gap);
         end
      end else
         m_gap++;
   end

   // Avalon read monitor: counts stall cycles and checks data when a read completes.
   rd_exp_t r_e;
   int      r_stall = 0;

   always @(negedge clk) begin
      if (!reset_n)
         r_stall = 0;
      else if (chipselect && !read_n && write_n) begin
         if (waitrequest)
            r_stall++;
         else begin
            if (rd_q.size() == 0)
               chk("rd_unexpected", 1, 0);
            else begin
               r_e = rd_q.pop_front();
               chk("rd_data", readdata, r_e.data);
               chk("rd_stall", r_stall, r_e.stall);
            end
            r_stall = 0;
         end
      end
   end

   task automatic av_write(input logic [1:0] a, input logic [31:0] d, input logic both);
      int n = 0;
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; read_n = !both;
      @(negedge clk);
      while (waitrequest && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) chk("wr_timeout", 1, 0);
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
   endtask

   task automatic av_read(input logic [1:0] a, input logic [31:0] d, input int stall);
      int n = 0;
      rd_exp_t e;
      e.data = d; e.stall = stall;
      rd_q.push_back(e);
      address = a; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1;
      @(negedge clk);
      while (waitrequest && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) chk("rd_timeout", 1, 0);
      @(posedge clk); #1;
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!lcd_cs_n && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) chk("idle_timeout", 1, 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic wait_strobe();
      int n = 0;
      while (lcd_wr_n && lcd_rd_n && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("strobe_timeout", 1, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk); #1;
      chk("rst_cs_n", lcd_cs_n, 1);
      chk("rst_wr_n", lcd_wr_n, 1);
      chk("rst_rd_n", lcd_rd_n, 1);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_oe", lcd_data_oe, 0);
      chk("rst_dout", lcd_data_out, 0);
      chk("rst_readdata", readdata, 0);
      chk("rst_wait", waitrequest, 0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      av_read(2'd2, 32'h0001_0201, 0);
      av_read(2'd3, 32'h0, 0);

      push_lcd(1'b0, 1'b1, 16'h002C, 1, 2, 1, -1);
      av_write(2'd0, 32'h2C, 1'b0);
      av_read(2'd3, 32'h1, 0);
      wait_idle();

      push_lcd(1'b1, 1'b1, 16'h1234, 1, 2, 1, -1);
      push_lcd(1'b1, 1'b1, 16'hABCD, 1, 2, 1, 1);
      av_write(2'd1, 32'h1234, 1'b0);
      av_write(2'd1, 32'hABCD, 1'b0);
      wait_idle();

      push_lcd(1'b0, 1'b1, 16'h0F0F, 1, 2, 1, -1);
      av_write(2'd0, 32'h0F0F, 1'b1);
      wait_idle();

      av_write(2'd2, 32'h0, 1'b0);
      lcd_data_in = 16'h5A5A;
`ifdef LCD_BUS_CTRL_READ_EN
      push_lcd(1'b1, 1'b0, 16'h0, 0, 0, 0, -1);
      av_read(2'd1, 32'h0000_5A5A, 4);
`else
      av_read(2'd1, 32'h0, 0);
`endif
      wait_idle();

      av_write(2'd2, 32'h0001_0201, 1'b0);
      push_lcd(1'b1, 1'b1, 16'h0011, 1, 2, 1, -1);
      push_lcd(1'b1, 1'b1, 16'h0022, 3, 3, 3, 1);
      av_write(2'd1, 32'h11, 1'b0);
      av_write(2'd2, 32'h0003_0303, 1'b0);
      av_write(2'd1, 32'h22, 1'b0);
      wait_idle();

      av_write(2'd3, 32'hFFFF_FFFF, 1'b0);
      av_read(2'd3, 32'h0, 0);
      av_read(2'd2, 32'h0003_0303, 0);

      av_write(2'd2, 32'h0000_FF00, 1'b0);
      push_lcd(1'b0, 1'b1, 16'hBEEF, 0, 255, 0, -1);
      av_write(2'd0, 32'hBEEF, 1'b0);
      wait_idle();

      av_write(2'd0, 32'h77, 1'b0);
      wait_strobe();
      reset_n = 1'b0;
      #1;
      chk("midrst_cs_n", lcd_cs_n, 1);
      chk("midrst_wr_n", lcd_wr_n, 1);
      chk("midrst_rd_n", lcd_rd_n, 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      av_read(2'd3, 32'h0, 0);
      av_read(2'd2, 32'h0001_0201, 0);

`ifdef LCD_BUS_CTRL_READ_EN
      lcd_data_in = 16'h1111;
      address = 2'd1; chipselect = 1'b1; read_n = 1'b0;
      wait_strobe();
      reset_n = 1'b0;
      #1;
      chk("rdrst_rd_n", lcd_rd_n, 1);
      chk("rdrst_cs_n", lcd_cs_n, 1);
      chipselect = 1'b0; read_n = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      lcd_data_in = 16'h2222;
      push_lcd(1'b1, 1'b0, 16'h0, 1, 2, 1, -1);
      av_read(2'd1, 32'h0000_2222, 8);
      wait_idle();
`endif

      repeat (4) @(negedge clk);
      chk("lcd_q_drained", lcd_q.size(), 0);
      chk("rd_q_drained", rd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
